// File: rtl/gp_register_file.sv
// gp_register_file: clocked general-purpose register file for the RISC-V datapath.
// Two registered read ports, one write port and a per-register busy scoreboard.
// Optional write-first bypass on the read data path: define GP_REGFILE_BYPASS_EN.
// Without it, a same-edge read of a register being written returns the old contents.
module gp_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic              wr_ok;
    logic              rsv_ok;
    logic [DATA_W-1:0] nxt_data1;
    logic [DATA_W-1:0] nxt_data2;
    logic              nxt_busy1;
    logic              nxt_busy2;

    // Qualify write and reserve: a hardwired r0 silently drops both.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ok  = wr_en;
        rsv_ok = rsv_en;
        if (ZERO_REG != 0) begin
            if (wr_addr == '0) begin
                wr_ok = 1'b0;
            end
            if (rsv_addr == '0) begin
                rsv_ok = 1'b0;
            end
        end
    end

    // Next read-port values: array lookup, optional write-first bypass, r0 forced to zero.
    always_comb begin
        nxt_data1 = mem[rd_addr1];
        nxt_data2 = mem[rd_addr2];
        nxt_busy1 = busy[rd_addr1];
        nxt_busy2 = busy[rd_addr2];
`ifdef GP_REGFILE_BYPASS_EN
        // Busy is deliberately not bypassed; only the data path sees the same-edge write.
        if (wr_ok && (wr_addr == rd_addr1)) begin
            nxt_data1 = wr_data;
        end
        if (wr_ok && (wr_addr == rd_addr2)) begin
            nxt_data2 = wr_data;
        end
`endif
        if (ZERO_REG != 0) begin
            if (rd_addr1 == '0) begin
                nxt_data1 = '0;
                nxt_busy1 = 1'b0;
            end
            if (rd_addr2 == '0) begin
                nxt_data2 = '0;
                nxt_busy2 = 1'b0;
            end
        end
    end

    // Register storage: updated by the writeback port.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the array is reset because its contents must read as zero after reset,
        // which keeps it in flops rather than a RAM macro.
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
            mem[wr_addr] <= wr_data;
        end
    end

    // Busy scoreboard: writeback clears, reserve sets; reserve is last so the new producer wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            if (wr_ok) begin
                busy[wr_addr] <= 1'b0;
            end
            if (rsv_ok) begin
                busy[rsv_addr] <= 1'b1;
            end
        end
    end

    // Registered read ports: load on rd_en, otherwise hold; rd_valid pulses per accepted read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_busy1 <= 1'b0;
            rd_busy2 <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data1 <= nxt_data1;
                rd_data2 <= nxt_data2;
                rd_busy1 <= nxt_busy1;
                rd_busy2 <= nxt_busy2;
            end
        end
    end

endmodule

// File: tb/tb_gp_register_file.sv
// tb_gp_register_file: drives one instance with ZERO_REG=1 and one with ZERO_REG=0 from the
// same stimulus. Expected read results come from a behavioural model, are queued when the
// read is issued and are popped when rd_valid shows the result.
module tb_gp_register_file;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

`ifdef GP_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic          b1;
        logic          b2;
    } rd_t;

    typedef struct packed {
        rd_t z;
        rd_t nz;
    } exp_t;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          rd_en    = 1'b0;
    logic [AW-1:0] rd_addr1 = '0;
    logic [AW-1:0] rd_addr2 = '0;
    logic          wr_en    = 1'b0;
    logic [AW-1:0] wr_addr  = '0;
    logic [DW-1:0] wr_data  = '0;
    logic          rsv_en   = 1'b0;
    logic [AW-1:0] rsv_addr = '0;

    logic [DW-1:0] rd_data1_z, rd_data2_z, rd_data1_nz, rd_data2_nz;
    logic          rd_busy1_z, rd_busy2_z, rd_busy1_nz, rd_busy2_nz;
    logic          rd_valid_z, rd_valid_nz;

    logic [DW-1:0]    m_mem  [2][DEPTH];
    logic [DEPTH-1:0] m_busy [2];
    exp_t             exp_q [$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gp_register_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset_n(reset_n), .rd_en(rd_en),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1_z), .rd_data2(rd_data2_z),
        .rd_busy1(rd_busy1_z), .rd_busy2(rd_busy2_z), .rd_valid(rd_valid_z),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    gp_register_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut_nz (
        .clk(clk), .reset_n(reset_n), .rd_en(rd_en),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1_nz), .rd_data2(rd_data2_nz),
        .rd_busy1(rd_busy1_nz), .rd_busy2(rd_busy2_nz), .rd_valid(rd_valid_nz),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    // Model index 0 is the ZERO_REG=1 instance, index 1 the ZERO_REG=0 instance.
    function automatic logic [DW-1:0] exp_word(input int k, input logic [AW-1:0] a,
                                               input logic we, input logic [AW-1:0] wa,
                                               input logic [DW-1:0] wd);
        if (k == 0 && a == '0) return '0;
        if (BYP && we && wa == a) return wd;
        return m_mem[k][a];
    endfunction

    function automatic logic exp_busy(input int k, input logic [AW-1:0] a);
        if (k == 0 && a == '0) return 1'b0;
        return m_busy[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
            m_busy[k] = '0;
        end
    endtask

    task automatic model_update(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic rse, input logic [AW-1:0] ra);
        for (int k = 0; k < 2; k++) begin
            if (we && !(k == 0 && wa == '0)) begin
                m_mem[k][wa]  = wd;
                m_busy[k][wa] = 1'b0;
            end
            if (rse && !(k == 0 && ra == '0)) m_busy[k][ra] = 1'b1;
        end
    endtask

    // One clock of stimulus: queue the expected read, update the model, then score the DUTs.
    task automatic cycle(input logic re, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic rse, input logic [AW-1:0] ra);
        exp_t e;
        rd_t  got_z, got_nz;
        rd_en = re; rd_addr1 = a1; rd_addr2 = a2;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = rse; rsv_addr = ra;
        if (re) begin
            e.z.d1  = exp_word(0, a1, we, wa, wd);
            e.z.d2  = exp_word(0, a2, we, wa, wd);
            e.z.b1  = exp_busy(0, a1);
            e.z.b2  = exp_busy(0, a2);
            e.nz.d1 = exp_word(1, a1, we, wa, wd);
            e.nz.d2 = exp_word(1, a2, we, wa, wd);
            e.nz.b1 = exp_busy(1, a1);
            e.nz.b2 = exp_busy(1, a2);
            exp_q.push_back(e);
        end
        model_update(we, wa, wd, rse, ra);
        @(posedge clk);
        #1;
        total++;
        if (rd_valid_z !== re || rd_valid_nz !== re) begin
            bad++;
            $display("FAIL rd_valid t=%0t got z=%b nz=%b want %b", $time, rd_valid_z, rd_valid_nz, re);
        end
        if (rd_valid_z === 1'b1 || rd_valid_nz === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty t=%0t got unexpected read want none", $time);
            end else begin
                e      = exp_q.pop_front();
                got_z  = '{rd_data1_z, rd_data2_z, rd_busy1_z, rd_busy2_z};
                got_nz = '{rd_data1_nz, rd_data2_nz, rd_busy1_nz, rd_busy2_nz};
                if (got_z !== e.z) begin
                    bad++;
                    $display("FAIL read_zero_reg t=%0t got d1=%h d2=%h b=%b%b want d1=%h d2=%h b=%b%b",
                             $time, got_z.d1, got_z.d2, got_z.b1, got_z.b2, e.z.d1, e.z.d2, e.z.b1, e.z.b2);
                end
                total++;
                if (got_nz !== e.nz) begin
                    bad++;
                    $display("FAIL read_plain_reg t=%0t got d1=%h d2=%h b=%b%b want d1=%h d2=%h b=%b%b",
                             $time, got_nz.d1, got_nz.d2, got_nz.b1, got_nz.b2, e.nz.d1, e.nz.d2, e.nz.b1, e.nz.b2);
                end
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic write(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        cycle(1'b0, '0, '0, 1'b1, wa, wd, 1'b0, '0);
    endtask

    task automatic read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        cycle(1'b1, a1, a2, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rd_valid_z, rd_busy1_z, rd_busy2_z, rd_data1_z, rd_data2_z} !== '0) begin
            bad++;
            $display("FAIL reset_state_z got v=%b b=%b%b d1=%h d2=%h want all zero",
                     rd_valid_z, rd_busy1_z, rd_busy2_z, rd_data1_z, rd_data2_z);
        end
        total++;
        if ({rd_valid_nz, rd_busy1_nz, rd_busy2_nz, rd_data1_nz, rd_data2_nz} !== '0) begin
            bad++;
            $display("FAIL reset_state_nz got v=%b b=%b%b d1=%h d2=%h want all zero",
                     rd_valid_nz, rd_busy1_nz, rd_busy2_nz, rd_data1_nz, rd_data2_nz);
        end
        @(negedge clk) reset_n = 1'b1;
        write(5'd5, 32'hDEADBEEF);
        read(5'd5, 5'd5);
        // Assert reset mid-cycle while rd_valid is high; it must drop with no clock edge.
        #1 reset_n = 1'b0;
        #1;
        total++;
        if (rd_valid_z !== 1'b0 || rd_valid_nz !== 1'b0 || rd_data1_z !== '0 || rd_data1_nz !== '0) begin
            bad++;
            $display("FAIL async_reset got v=%b%b d1=%h/%h want v=00 d1=0",
                     rd_valid_z, rd_valid_nz, rd_data1_z, rd_data1_nz);
        end
        model_reset();
        exp_q.delete();
        @(negedge clk) reset_n = 1'b1;
        read(5'd5, 5'd5);
        idle();
    endtask

    task automatic test_basic();
        write(5'd3, 32'h12345678);
        write(5'd7, 32'hCAFEF00D);
        read(5'd3, 5'd7);
        idle();
    endtask

    task automatic test_zero_reg();
        cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
        read(5'd0, 5'd0);
        // Same-edge write to r0 with a read of r0 exercises the bypass guard.
        cycle(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0BADF00D, 1'b0, '0);
        idle();
    endtask

    task automatic test_collision();
        write(5'd9, 32'h1);
        cycle(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 32'h2, 1'b0, '0);
        read(5'd9, 5'd9);
        idle();
    endtask

    task automatic test_scoreboard();
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4);
        read(5'd4, 5'd0);
        write(5'd4, 32'hA5A5A5A5);
        read(5'd4, 5'd0);
        cycle(1'b0, '0, '0, 1'b1, 5'd4, 32'h5A5A5A5A, 1'b1, 5'd4);
        read(5'd4, 5'd0);
        // Busy read during a same-edge write returns the pre-edge busy.
        cycle(1'b1, 5'd4, 5'd4, 1'b1, 5'd4, 32'h00C0FFEE, 1'b0, '0);
        read(5'd4, 5'd4);
        // Busy read during a same-edge reserve returns the pre-edge busy.
        cycle(1'b1, 5'd6, 5'd4, 1'b0, '0, '0, 1'b1, 5'd6);
        read(5'd6, 5'd6);
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) write(AW'(i), DW'(16 * i));
        for (int i = 1; i <= 8; i++) read(AW'(i), AW'(9 - i));
        idle();
        idle();
        total++;
        if (rd_data1_z !== 32'h80 || rd_data1_nz !== 32'h80 ||
            rd_data2_z !== 32'h10 || rd_data2_nz !== 32'h10) begin
            bad++;
            $display("FAIL hold got d1=%h/%h d2=%h/%h want d1=80 d2=10",
                     rd_data1_z, rd_data1_nz, rd_data2_z, rd_data2_nz);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom()),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
        end
        idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_reg();
        test_collision();
        test_scoreboard();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
